// File: rtl/modcore_s_axil_regs.sv
// AXI4-Lite slave register file with four 32-bit software registers.
// Write address and write data are each held in a one-entry slot until both
// are present and no write response is outstanding; then the word is merged
// into the addressed register under the byte strobes. Reads return registered
// data from the register contents seen before any commit on the same edge.
module modcore_s_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG0_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG1_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG2_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG3_OUT
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [DW-1:0]     regs [4];

    // Write-channel holding slots
    logic              aw_full;
    logic              w_full;
    logic [1:0]        aw_idx;
    logic [DW-1:0]     w_data;
    logic [STRB_W-1:0] w_strb;

    logic              awready;
    logic              wready;
    logic              bvalid;
    logic              arready;
    logic              rvalid;
    logic [DW-1:0]     rdata;

    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              ar_hs;
    logic              r_hs;
    logic              commit;
    logic              aw_full_next;
    logic              w_full_next;
    logic              bvalid_next;
    logic              rvalid_next;

    // Protection bits and the byte offset within a word carry no meaning here
    logic              unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Replace only the strobed bytes of the old word
    function automatic logic [DW-1:0] merge_strobes(input logic [DW-1:0]     old_word,
                                                    input logic [DW-1:0]     new_word,
                                                    input logic [STRB_W-1:0] strb);
        logic [DW-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign aw_hs  = S_AXI_AWVALID & awready;
    assign w_hs   = S_AXI_WVALID & wready;
    assign b_hs   = bvalid & S_AXI_BREADY;
    assign ar_hs  = S_AXI_ARVALID & arready;
    assign r_hs   = rvalid & S_AXI_RREADY;
    // A commit needs both halves of the write and a free response slot
    assign commit = aw_full & w_full & ~bvalid;

    // Next state of the write holding flags and response valid
    always_comb begin
        aw_full_next = aw_full;
        w_full_next  = w_full;
        bvalid_next  = bvalid;
        if (commit) begin
            aw_full_next = 1'b0;
            w_full_next  = 1'b0;
        end else begin
            if (aw_hs) aw_full_next = 1'b1;
            if (w_hs)  w_full_next  = 1'b1;
        end
        if (commit) begin
            bvalid_next = 1'b1;
        end else if (b_hs) begin
            bvalid_next = 1'b0;
        end
    end

    // Next state of the read response valid
    always_comb begin
        rvalid_next = rvalid;
        if (ar_hs) begin
            rvalid_next = 1'b1;
        end else if (r_hs) begin
            rvalid_next = 1'b0;
        end
    end

    // Write-path control: holding flags, registered readies, response valid
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            aw_full <= aw_full_next;
            w_full  <= w_full_next;
            awready <= ~aw_full_next;
            wready  <= ~w_full_next;
            bvalid  <= bvalid_next;
        end
    end

    // Capture address index, data and strobes on their handshakes
    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            aw_idx <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
        end
    end

    // Register array update on commit
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[aw_idx] <= merge_strobes(regs[aw_idx], w_data, w_strb);
        end
    end

    // Read path: data sampled from pre-commit contents, held until accepted
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid  <= 1'b0;
            arready <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid  <= rvalid_next;
            arready <= ~rvalid_next;
            if (ar_hs) begin
                rdata <= regs[S_AXI_ARADDR[3:2]];
            end
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign REG0_OUT      = regs[0];
    assign REG1_OUT      = regs[1];
    assign REG2_OUT      = regs[2];
    assign REG3_OUT      = regs[3];

endmodule

// File: tb/tb_modcore_s_axil_regs.sv
// Bench for modcore_s_axil_regs: directed AXI4-Lite transactions, a
// transaction-level model of the register file compared every cycle, and
// literal expectations for the key scenarios.
module tb_modcore_s_axil_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    modcore_s_axil_regs dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .REG0_OUT(reg0_out), .REG1_OUT(reg1_out), .REG2_OUT(reg2_out), .REG3_OUT(reg3_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // ---------------- behavioural model ----------------
    // Accepted addresses and data wait in queues; a write completes once both
    // are present and no response is pending. Ready means "slot empty".
    logic [31:0] m_reg [4];
    logic [1:0]  m_awq [$];
    logic [31:0] m_wdq [$];
    logic [3:0]  m_wsq [$];
    bit          m_valid = 0;
    bit          m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
    logic [31:0] m_rdata;

    initial begin
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, done;
        logic [31:0] word, d;
        logic [3:0]  s;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1;
                for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
                m_awq.delete(); m_wdq.delete(); m_wsq.delete();
                m_awready = 0; m_wready = 0; m_arready = 0;
                m_bvalid = 0; m_rvalid = 0; m_rdata = 32'h0;
            end else begin
                aw_hs = awvalid && m_awready;
                w_hs  = wvalid && m_wready;
                ar_hs = arvalid && m_arready;
                b_hs  = m_bvalid && bready;
                r_hs  = m_rvalid && rready;
                done  = (m_awq.size() > 0) && (m_wdq.size() > 0) && !m_bvalid;
                if (ar_hs) begin
                    m_rdata  = m_reg[araddr[3:2]];
                    m_rvalid = 1;
                end else if (r_hs) begin
                    m_rvalid = 0;
                end
                if (done) begin
                    word = m_reg[m_awq[0]];
                    d = m_wdq[0];
                    s = m_wsq[0];
                    for (int b = 0; b < 4; b++)
                        if (s[b]) word = (word & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
                    m_reg[m_awq[0]] = word;
                    void'(m_awq.pop_front()); void'(m_wdq.pop_front()); void'(m_wsq.pop_front());
                    m_bvalid = 1;
                end else if (b_hs) begin
                    m_bvalid = 0;
                end
                if (aw_hs) m_awq.push_back(awaddr[3:2]);
                if (w_hs) begin
                    m_wdq.push_back(wdata);
                    m_wsq.push_back(wstrb);
                end
                m_awready = (m_awq.size() == 0);
                m_wready  = (m_wdq.size() == 0);
                m_arready = !m_rvalid;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("awready", {31'b0, awready}, {31'b0, m_awready});
                chk("wready",  {31'b0, wready},  {31'b0, m_wready});
                chk("arready", {31'b0, arready}, {31'b0, m_arready});
                chk("bvalid",  {31'b0, bvalid},  {31'b0, m_bvalid});
                chk("rvalid",  {31'b0, rvalid},  {31'b0, m_rvalid});
                chk("rdata",   rdata, m_rdata);
                chk("bresp",   {30'b0, bresp}, 32'h0);
                chk("rresp",   {30'b0, rresp}, 32'h0);
                chk("reg0_out", reg0_out, m_reg[0]);
                chk("reg1_out", reg1_out, m_reg[1]);
                chk("reg2_out", reg2_out, m_reg[2]);
                chk("reg3_out", reg3_out, m_reg[3]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ad, wd, a_now, w_now, got;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1; bready = 1;
        ad = 0; wd = 0; n = 0;
        while (!(ad && wd)) begin
            @(negedge clk);
            a_now = awvalid && awready;
            w_now = wvalid && wready;
            tick();
            if (a_now) begin ad = 1; awvalid = 0; end
            if (w_now) begin wd = 1; wvalid = 0; end
            n++;
            if (n > 20) begin
                timeout("write_addr_data");
                awvalid = 0; wvalid = 0;
                return;
            end
        end
        got = 0; n = 0;
        while (!got) begin
            @(negedge clk);
            if (bvalid) begin
                got = 1;
                chk("write_bresp", {30'b0, bresp}, 32'h0);
            end
            tick();
            n++;
            if (n > 20) begin
                timeout("write_resp");
                return;
            end
        end
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit done, a_now;
        int n;
        d = 32'hDEAD_BEEF;
        araddr = a; arvalid = 1; rready = 1;
        done = 0; n = 0;
        while (!done) begin
            @(negedge clk);
            a_now = arready;
            tick();
            if (a_now) begin done = 1; arvalid = 0; end
            n++;
            if (n > 20) begin
                timeout("read_addr");
                arvalid = 0;
                return;
            end
        end
        done = 0; n = 0;
        while (!done) begin
            @(negedge clk);
            if (rvalid) begin
                done = 1;
                d = rdata;
                chk("read_rresp", {30'b0, rresp}, 32'h0);
            end
            tick();
            n++;
            if (n > 20) begin
                timeout("read_data");
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] rd;
        int bcnt;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_awready", {31'b0, awready}, 32'h0);
        chk("rst_arready", {31'b0, arready}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 0;
        tick();
        @(negedge clk);
        chk("post_rst_awready", {31'b0, awready}, 32'h1);
        chk("post_rst_wready",  {31'b0, wready},  32'h1);
        chk("post_rst_arready", {31'b0, arready}, 32'h1);
        tick();

        // Basic writes and reads of all four registers
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'(i * 4);
            axi_read(a, rd);
            chk("basic_read", rd, 32'(i + 1));
        end
        @(negedge clk);
        chk("basic_reg0", reg0_out, 32'h1);
        chk("basic_reg3", reg3_out, 32'h4);
        tick();
        // Low address bits are ignored
        axi_read(4'hE, rd);
        chk("read_unaligned", rd, 32'h4);

        // Byte strobes
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'h4, 32'hAABB_CCDD, 4'b0101);
        axi_read(4'h4, rd);
        chk("strobe_merge", rd, 32'hFFBB_FFDD);
        // All strobes off: response but no change
        axi_write(4'h0, 32'h9999_9999, 4'b0000);
        axi_read(4'h0, rd);
        chk("strobe_zero", rd, 32'h1);

        // W two cycles before AW, BREADY held low
        bready = 0;
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        tick();
        awaddr = 4'hC; awvalid = 1;
        tick();
        awvalid = 0;
        tick();
        awaddr = 4'h0; awvalid = 1;
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1;
        bcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bvalid) bcnt++;
            if (i == 0) chk("held_reg3", reg3_out, 32'h1234_5678);
            if (i >= 1) begin
                chk("held_awready", {31'b0, awready}, 32'h0);
                chk("held_wready",  {31'b0, wready},  32'h0);
                chk("held_reg0",    reg0_out, 32'h1);
            end
            tick();
            if (i == 0) begin awvalid = 0; wvalid = 0; end
        end
        chk("bvalid_hold_cycles", 32'(bcnt), 32'd5);
        bready = 1;
        tick();
        @(negedge clk);
        chk("bvalid_cleared", {31'b0, bvalid}, 32'h0);
        tick();
        @(negedge clk);
        chk("second_commit_bvalid", {31'b0, bvalid}, 32'h1);
        chk("second_commit_reg0", reg0_out, 32'hCAFE_F00D);
        tick();

        // Read on the commit edge returns the old value
        awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 1;
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 4'h8; arvalid = 1; rready = 0;
        tick();
        arvalid = 0;
        @(negedge clk);
        chk("same_edge_old", rdata, 32'h3);
        chk("same_edge_rvalid", {31'b0, rvalid}, 32'h1);
        chk("same_edge_reg2", reg2_out, 32'h55);
        rready = 1;
        tick();
        axi_read(4'h8, rd);
        chk("reread_new", rd, 32'h55);

        // RREADY low for 4 cycles after AR
        araddr = 4'h4; arvalid = 1; rready = 0;
        tick();
        arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_rvalid",  {31'b0, rvalid},  32'h1);
            chk("stall_rdata",   rdata, 32'hFFBB_FFDD);
            chk("stall_arready", {31'b0, arready}, 32'h0);
            tick();
        end
        rready = 1;
        tick();
        @(negedge clk);
        chk("stall_arready_back", {31'b0, arready}, 32'h1);
        chk("stall_rvalid_clr",   {31'b0, rvalid},  32'h0);
        tick();

        // Reset mid-transaction: AW held, read response pending
        awaddr = 4'h4; awvalid = 1; wvalid = 0; bready = 1;
        araddr = 4'h0; arvalid = 1; rready = 0;
        tick();
        awvalid = 0; arvalid = 0;
        @(negedge clk);
        chk("pre_rst_awready", {31'b0, awready}, 32'h0);
        chk("pre_rst_rvalid",  {31'b0, rvalid},  32'h1);
        rst = 1;
        tick();
        @(negedge clk);
        chk("mid_rst_rvalid",  {31'b0, rvalid},  32'h0);
        chk("mid_rst_awready", {31'b0, awready}, 32'h0);
        chk("mid_rst_rdata",   rdata, 32'h0);
        chk("mid_rst_reg0",    reg0_out, 32'h0);
        chk("mid_rst_reg1",    reg1_out, 32'h0);
        rst = 0;
        rready = 1;
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("no_stray_bvalid", {31'b0, bvalid}, 32'h0);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'(i * 4);
            axi_read(a, rd);
            chk("rst_readback", rd, 32'h0);
        end
        axi_write(4'h8, 32'hA5A5_0001, 4'hF);
        axi_read(4'h8, rd);
        chk("after_rst_write", rd, 32'hA5A5_0001);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modcore_s_axil_regs.md
# modcore_s_axil_regs

AXI4-Lite slave register file answering the master-side transactions issued toward the modcore S00_AXI port. Holds four 32-bit software registers, accepts write address and write data independently with one-entry holding per channel, applies byte strobes, and returns registered read data. Sits between the AXI interconnect and modcore control logic; register contents are also driven out for fabric use.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 4, byte address width; register index = addr[3:2], addr[1:0] ignored
- ACLK  in  1  clock, all logic rising-edge
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  4  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2  always 2'b00 (OKAY)
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  4 / S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- REG0_OUT..REG3_OUT  out  32 each  current register contents

## Operation
- All outputs registered. Handshake = VALID & READY sampled at a rising edge.
- Write path: aw_full / w_full holding flags with captured address, data, strobes.
  - AWREADY = ~aw_full, WREADY = ~w_full (registered equivalents).
  - AW handshake sets aw_full; W handshake sets w_full; either order, same edge allowed.
  - Commit when aw_full & w_full & ~BVALID: for each byte b with strb[b]=1, reg[idx][8b+7:8b] <= data byte; BVALID <= 1; aw_full, w_full cleared.
  - BVALID held until B handshake; cleared at that edge. While BVALID=1, at most one further AW and one W are accepted and held; commit waits.
  - WSTRB = 0: commit still occurs, no register change, OKAY response.
- Read path:
  - ARREADY = ~RVALID.
  - AR handshake at edge N: RDATA <= reg[ARADDR[3:2]] (value before any commit at edge N), RVALID <= 1.
  - RVALID, RDATA held stable until R handshake; RVALID cleared at that edge.
- Read and write channels independent; no ordering between them.
- Reset (any time, including mid-transaction): registers, holding flags, BVALID, RVALID, RDATA cleared; in-flight transactions dropped, no response issued.

## Timing
- Reset values: AWREADY 0, WREADY 0, ARREADY 0, BVALID 0, RVALID 0, RDATA 0, BRESP 0, RRESP 0, REG*_OUT 0.
- First edge with ARESET=0: AWREADY, WREADY, ARREADY go 1.
- Write latency: later of AW/W handshake at edge N -> commit and BVALID=1 at edge N+1; REGx_OUT updates at N+1.
- AWREADY/WREADY low for the cycle following their handshake, high again after commit edge.
- Back-to-back writes with BREADY tied 1: one write per 2 cycles.
- Read latency: AR handshake at edge N -> RVALID=1 with data at N+1 output. ARREADY low while RVALID=1; returns high the edge after R handshake. Max one read per 2 cycles with RREADY tied 1.
- Same-edge commit and AR to same index: read returns old value; next read returns new value.
- Out-of-range addresses impossible (4-bit space fully decoded).

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read each -> BRESP/RRESP 0, RDATA 0x1..0x4, REG0..3_OUT match.
- Write 0xFFFFFFFF to 0x4, then 0xAABBCCDD with WSTRB=4'b0101 -> read 0x4 returns 0xFFBBFFDD.
- Present W two cycles before AW, BREADY low 5 cycles -> single commit one edge after AW handshake, BVALID held 5 cycles, second AW/W each accepted once then READY stays low until B handshake.
- Write 0x55 to 0x8 with AR to 0x8 on commit edge -> first RDATA old value, immediate re-read 0x55.
- Hold RREADY low 4 cycles after AR -> RVALID/RDATA stable, ARREADY 0 throughout, ARREADY 1 the edge after handshake.
- Assert ARESET with aw_full set and RVALID=1 -> all outputs at reset values next edge, registers read back 0, no stray BVALID.
